// File: rtl/word_memory_if.sv
// word_memory_if: address/strobe/data bus between the bus controller and the word memory
interface word_memory_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 16
) ();
  logic [ADDR_WIDTH-1:0] adress;
  logic                  write;
  logic [DATA_WIDTH-1:0] indata;
  logic [DATA_WIDTH-1:0] outdata;
  modport master (output adress, write, indata, input outdata);
  modport slave  (input adress, write, indata, output outdata);
endinterface

// File: rtl/word_memory.sv
// word_memory: 4096x16 single-port RAM, write-first, registered read, storage kept across reset
module word_memory #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 2**ADDR_WIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  word_memory_if.slave bus
);
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_out;
  logic [DATA_WIDTH-1:0] w_rd;
  assign w_rd        = bus.write ? bus.indata : r_mem[bus.adress];
  assign bus.outdata = r_out;
  always_ff @(posedge clk) begin
    if (rst_n && bus.write) r_mem[bus.adress] <= bus.indata;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_out <= '0;
    else        r_out <= w_rd;
  end
endmodule

// File: tb/tb_word_memory.sv
// tb_word_memory: vector table, exhaustive fill and random traffic checked against an array model
module tb_word_memory;
  logic clk = 1'b0;
  logic rst_n;
  int checks = 0;
  int errors = 0;
  int unsigned mdl [4096];

  word_memory_if #(.ADDR_WIDTH(12), .DATA_WIDTH(16)) bus ();
  word_memory dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [11:0] addr;
    logic [15:0] din;
    logic [15:0] exp;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic drive(input logic wr, input logic [11:0] a, input logic [15:0] d);
    bus.write  = wr;
    bus.adress = a;
    bus.indata = d;
  endtask

  task automatic do_cycle(input logic wr, input logic [11:0] a, input logic [15:0] d);
    drive(wr, a, d);
    tick();
    if (wr) mdl[a] = {16'h0, d};
  endtask

  vec_t vecs [11];

  initial begin
    vecs[0]  = '{1'b1, 12'd4095, 16'hFFFF, 16'hFFFF};
    vecs[1]  = '{1'b1, 12'd0,    16'h0001, 16'h0001};
    vecs[2]  = '{1'b0, 12'd4095, 16'h0000, 16'hFFFF};
    vecs[3]  = '{1'b0, 12'd0,    16'hFFFF, 16'h0001};
    vecs[4]  = '{1'b1, 12'h123,  16'h1111, 16'h1111};
    vecs[5]  = '{1'b1, 12'h123,  16'h2222, 16'h2222};
    vecs[6]  = '{1'b0, 12'h123,  16'h0000, 16'h2222};
    vecs[7]  = '{1'b0, 12'h123,  16'h5555, 16'h2222};
    vecs[8]  = '{1'b0, 12'h123,  16'hAAAA, 16'h2222};
    vecs[9]  = '{1'b0, 12'd4095, 16'h1234, 16'hFFFF};
    vecs[10] = '{1'b0, 12'd0,    16'h4321, 16'h0001};

    rst_n = 1'b0;
    drive(1'b0, '0, '0);
    #1;
    check("reset_initial", bus.outdata, 16'h0000);
    tick();
    rst_n = 1'b1;

    do_cycle(1'b1, 12'd5, 16'hBEEF);
    check("write_first_5", bus.outdata, 16'hBEEF);
    drive(1'b1, 12'd5, 16'h0000);
    rst_n = 1'b0;
    #1;
    check("async_reset", bus.outdata, 16'h0000);
    tick();
    tick();
    check("reset_hold", bus.outdata, 16'h0000);
    rst_n = 1'b1;
    do_cycle(1'b0, 12'd5, 16'h0000);
    check("retained_5", bus.outdata, 16'hBEEF);

    for (int i = 0; i < 4096; i++) begin
      do_cycle(1'b1, i[11:0], i[15:0]);
      if (bus.outdata !== i[15:0]) check("fill_wf", bus.outdata, i[15:0]);
    end
    checks++;
    for (int i = 0; i < 4096; i++) begin
      do_cycle(1'b0, i[11:0], 16'hDEAD);
      if (bus.outdata !== mdl[i][15:0]) check("fill_read", bus.outdata, mdl[i][15:0]);
    end
    checks++;

    for (int i = 0; i < 11; i++) begin
      do_cycle(vecs[i].wr, vecs[i].addr, vecs[i].din);
      check($sformatf("vec%0d", i), bus.outdata, vecs[i].exp);
    end

    for (int it = 0; it < 3750; it++) begin
      logic [11:0] a;
      logic [11:0] ra;
      logic [15:0] d;
      int n;
      a  = 12'($urandom);
      d  = 16'($urandom);
      n  = int'($urandom_range(1, 3));
      for (int k = 0; k < n; k++) begin
        do_cycle(1'b1, a, d);
        if (bus.outdata !== d) check("rnd_wf", bus.outdata, d);
      end
      do_cycle(1'b0, a, 16'($urandom));
      check("rnd_read", bus.outdata, mdl[a][15:0]);
      ra = 12'($urandom);
      do_cycle(1'b0, ra, 16'($urandom));
      if (bus.outdata !== mdl[ra][15:0]) check("rnd_other", bus.outdata, mdl[ra][15:0]);
      checks++;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
